// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared response type and byte-lane swap helper for ram_port
package ram_pkg;

  localparam int MAX_W = 512;

  typedef struct packed {
    logic             err;
    logic [MAX_W-1:0] rdata;
  } rsp_t;

  // Reverses the low nbytes byte lanes of d; lanes above nbytes come back zero.
  function automatic logic [MAX_W-1:0] lane_swap(input logic [MAX_W-1:0] d, input int nbytes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W / 8; i++) begin
      if (i < nbytes) r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// rtl/rsp_fifo2.sv - two-entry in-order response buffer; the caller never pushes when full
module rsp_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             m_tready
);

  logic [WIDTH-1:0] data_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign pop = m_tvalid && m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ s_tvalid;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, s_tvalid} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_tvalid) data_q[wr_ptr_q] <= s_tdata;
  end

  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = data_q[rd_ptr_q];

endmodule

// File: rtl/ram_port.sv
// rtl/ram_port.sv - byte-maskable single-port RAM behind a request/response handshake
module ram_port import ram_pkg::*; #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 64,
  parameter int BYTE_SWAP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_mask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  ram_idx;
  logic              in_range, accept, hs, wr_en, rd_en, push, head_vld;
  logic [NB-1:0]     st_mask;
  logic [DATA_W-1:0] st_wdata;
  logic [1:0]        out_q, out_d;
  logic              req_ready_q, req_ready_d;
  logic              s1_vld_q, s1_vld_d, s1_err_q, s1_err_d, s1_rd_q, s1_rd_d;
  rsp_t              s1_rsp, head_rsp, out_rsp;

  assign word_addr = req_addr >> OFF_W;
  assign in_range  = ((word_addr >> IDX_W) == '0);
  assign ram_idx   = word_addr[IDX_W-1:0];
  assign accept    = rst_n && req_valid && req_ready_q;
  assign wr_en     = accept && req_we && in_range;
  assign rd_en     = accept && !req_we && in_range;
  assign rsp_valid = head_vld || s1_vld_q;
  assign hs        = rsp_valid && rsp_ready;

  always_comb begin
    st_wdata = req_wdata;
    st_mask  = req_mask;
    if (BYTE_SWAP != 0) begin
      st_wdata = DATA_W'(lane_swap(MAX_W'(req_wdata), NB));
      for (int i = 0; i < NB; i++) st_mask[i] = req_mask[NB-1-i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && st_mask[i]) mem[ram_idx][i*8 +: 8] <= st_wdata[i*8 +: 8];
    end
    if (rd_en) ram_rd_q <= mem[ram_idx];
  end

  // s1 holds the response for the request accepted on the previous edge, for one cycle only.
  always_comb begin
    s1_vld_d    = accept;
    s1_err_d    = accept && !in_range;
    s1_rd_d     = rd_en;
    out_d       = out_q + {1'b0, accept} - {1'b0, hs};
    req_ready_d = (out_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= 2'd0;
      req_ready_q <= 1'b1;
      s1_vld_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_rd_q     <= 1'b0;
    end else begin
      out_q       <= out_d;
      req_ready_q <= req_ready_d;
      s1_vld_q    <= s1_vld_d;
      s1_err_q    <= s1_err_d;
      s1_rd_q     <= s1_rd_d;
    end
  end

  // Older buffered responses take precedence; s1 is parked in the buffer unless consumed directly.
  always_comb begin
    s1_rsp     = '0;
    s1_rsp.err = s1_err_q;
    if (s1_rd_q) begin
      s1_rsp.rdata = (BYTE_SWAP != 0) ? lane_swap(MAX_W'(ram_rd_q), NB) : MAX_W'(ram_rd_q);
    end
    push    = s1_vld_q && (head_vld || !rsp_ready);
    out_rsp = '0;
    if (head_vld)      out_rsp = head_rsp;
    else if (s1_vld_q) out_rsp = s1_rsp;
  end

  rsp_fifo2 #(.WIDTH($bits(rsp_t))) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (push),
    .s_tdata  (s1_rsp),
    .m_tvalid (head_vld),
    .m_tdata  (head_rsp),
    .m_tready (rsp_ready)
  );

  assign rsp_rdata = DATA_W'(out_rsp.rdata);
  assign rsp_err   = out_rsp.err;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_ram_port.sv
// tb/tb_ram_port.sv - directed and randomized checks of ram_port against a byte-level model
module tb_ram_port;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 64;
  localparam int NB     = 8;
  localparam int NW     = 16;

  logic              clk = 1'b0;
  logic              rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_mask;
  logic [DATA_W-1:0] req_wdata, rsp_rdata;

  always #5 clk = ~clk;

  ram_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_SWAP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_mask  (req_mask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  mem_m [DEPTH][NB];
  logic [63:0] pre [NW];
  int          n_checks = 0, n_errors = 0, cyc = 0, hs_cyc = -1, prev_hs_cyc = -1, n_hs = 0;
  logic        acc_last;
  logic [63:0] last_rdata, hold_data;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_accept();
    logic [63:0] w;
    logic [11:0] wi;
    exp_t        e;
    w = req_addr >> 3;
    wi = w[11:0];
    e.rdata = '0;
    e.err = 1'b0;
    if (w >= 64'(DEPTH)) e.err = 1'b1;
    else if (req_we) begin
      for (int i = 0; i < NB; i++) if (req_mask[i]) mem_m[wi][i] = req_wdata[i*8 +: 8];
    end else begin
      for (int i = 0; i < NB; i++) e.rdata[i*8 +: 8] = mem_m[wi][i];
    end
    exp_q.push_back(e);
  endtask

  // One clock: sample at negedge, update the model, then return just after the rising edge.
  task automatic tick();
    int   n_out;
    logic hs;
    @(negedge clk);
    n_out = exp_q.size();
    if (rst_n) begin
      check("req_ready", 64'(req_ready), 64'(n_out < 2));
      check("rsp_valid", 64'(rsp_valid), 64'(n_out > 0));
      if (rsp_valid && n_out > 0) begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
      end else if (!rsp_valid) begin
        check("idle_rdata", rsp_rdata, 64'd0);
        check("idle_err", 64'(rsp_err), 64'd0);
      end
    end
    acc_last = rst_n && req_valid && req_ready;
    hs = rst_n && rsp_valid && rsp_ready;
    if (hs && n_out > 0) begin
      last_rdata = rsp_rdata;
      last_err = rsp_err;
      void'(exp_q.pop_front());
      prev_hs_cyc = hs_cyc;
      hs_cyc = cyc;
      n_hs++;
    end
    if (acc_last) model_accept();
    if (!rst_n) exp_q.delete();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] wd);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_mask = mask;
    req_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc_last) break;
    end
    check("accept", 64'(acc_last), 64'd1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] word, d;
    int          base;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_mask = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rdata", rsp_rdata, 64'd0);
    rst_n = 1'b1;

    for (int w = 0; w < NW; w++) begin
      pre[w] = {$urandom, $urandom};
      req(1'b1, 64'(w * 8), 8'hFF, pre[w]);
    end
    drain();

    req(1'b1, 64'h10, 8'hFF, 64'h0123456789ABCDEF);
    req(1'b0, 64'h10, 8'h00, 64'd0);
    check("read_latency", 64'(rsp_valid), 64'd1);
    drain();
    check("wr_rd_0x10", last_rdata, 64'h0123456789ABCDEF);
    check("wr_rd_0x10_err", 64'(last_err), 64'd0);

    req(1'b1, 64'h10, 8'hFF, 64'd0);
    req(1'b1, 64'h10, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
    req(1'b0, 64'h13, 8'h00, 64'd0);
    drain();
    check("masked_write", last_rdata, 64'h00000000FFFFFFFF);

    d = 64'hA5A55A5A_C3C33C3C;
    req(1'b1, 64'h20, 8'hFF, d);
    req(1'b0, 64'h20, 8'h00, 64'd0);
    drain();
    check("b2b_data", last_rdata, d);
    check("b2b_gap", 64'(hs_cyc - prev_hs_cyc), 64'd1);

    rsp_ready = 1'b0;
    base = n_hs;
    req(1'b0, 64'h00, 8'h00, 64'd0);
    req(1'b0, 64'h08, 8'h00, 64'd0);
    check("ready_full", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    req_addr = 64'h18;
    hold_data = rsp_rdata;
    check("stall_first", hold_data, pre[0]);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold", rsp_rdata, hold_data);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (acc_last) break;
    end
    drain();
    check("stall_count", 64'(n_hs - base), 64'd3);
    check("stall_last", last_rdata, pre[3]);

    req(1'b0, 64'(DEPTH * 8), 8'h00, 64'd0);
    drain();
    check("oob_err", 64'(last_err), 64'd1);
    check("oob_rdata", last_rdata, 64'd0);
    req(1'b1, 64'(DEPTH * 8 + 8), 8'hFF, ~pre[1]);
    drain();
    check("oob_wr_err", 64'(last_err), 64'd1);
    for (int w = 0; w < NW; w++) req(1'b0, 64'(w * 8), 8'h00, 64'd0);
    drain();
    req(1'b0, 64'h08, 8'h00, 64'd0);
    drain();
    check("oob_no_alias", last_rdata, pre[1]);

    rsp_ready = 1'b0;
    req(1'b0, 64'h18, 8'h00, 64'd0);
    req(1'b0, 64'h20, 8'h00, 64'd0);
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 64'h18;
    req_mask = 8'hFF;
    req_wdata = ~pre[3];
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 1'b0;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    repeat (3) tick();
    req(1'b0, 64'h18, 8'h00, 64'd0);
    drain();
    check("rst_no_commit", last_rdata, pre[3]);

    for (int c = 0; c < 800; c++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < NW) word = 64'(r);
      else if (r < 19) word = 64'(DEPTH) + 64'($urandom_range(0, 300));
      else word = {24'd0, $urandom, 8'd1};
      req_valid = ($urandom_range(0, 9) < 7);
      req_we = 1'($urandom_range(0, 1));
      req_addr = (word << 3) + 64'($urandom_range(0, 7));
      req_mask = 8'($urandom);
      req_wdata = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
